// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full adder composed of two half-add stages and a carry OR.
module serial_add_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = a_i ^ b_i;
  assign h1_c = a_i & b_i;
  assign s_o  = h1_s ^ c_i;
  assign h2_c = h1_s & c_i;
  assign c_o  = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock, result published with a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             carry_q;
  logic             carry_d;
  logic             sum_bit;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  serial_add_cell u_cell (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (sum_bit),
    .c_o (carry_d)
  );

  // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
  assign res_d = {sum_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          res_q   <= res_d;
          carry_q <= carry_d;
          // Counter stops at the final bit rather than wrapping.
          if (cnt_q == LAST_BIT) begin
            sum_q   <= res_d;
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Table-driven, scoreboarded bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t         sb_q[$];
  vec_t         vecs[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] last_sum;
  logic         last_cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic drive_start(input vec_t v, input bit push);
    exp_t e;
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
    start = 1'b1;
    if (push) begin
      e.sum  = v.sum;
      e.cout = v.cout;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Waits for done, checks latency, busy span, held outputs and the scoreboard.
  task automatic wait_result(input string tag, input int inject_at);
    exp_t e;
    int   k;
    int   busy_cnt = 0;
    int   hold_bad = 0;
    bit   seen = 0;
    for (k = 0; k <= 20; k++) begin
      if (k == inject_at) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h11;
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      busy_cnt += int'(busy);
      if (sum !== last_sum || cout !== last_cout) hold_bad++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_timeout"}, 32'(0), 32'(1));
      return;
    end
    check({tag, "_latency"}, 32'(k), 32'(W));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_held_prev"}, 32'(hold_bad), 32'(0));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(0), 32'(1));
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_sum"}, 32'(sum), 32'(e.sum));
    check({tag, "_cout"}, 32'(cout), 32'(e.cout));
    last_sum  = e.sum;
    last_cout = e.cout;
  endtask

  initial begin
    vec_t v;
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 8'h47, 1'b0});

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum",  32'(sum),  32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, each followed by a check that done was a single pulse.
    foreach (vecs[i]) begin
      drive_start(vecs[i], 1'b1);
      wait_result($sformatf("vec%0d", i), 100);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'(0));
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'(0));
    end

    // Start with new operands mid-RUN must be ignored.
    drive_start('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0}, 1'b1);
    wait_result("ignore", 3);
    @(negedge clk);
    check("ignore_done_pulse", 32'(done), 32'(0));
    check("ignore_no_rerun", 32'(busy), 32'(0));

    // Reset during the fourth RUN edge aborts the addition.
    drive_start('{8'h33, 8'h44, 1'b0, 8'h77, 1'b0}, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sum",  32'(sum),  32'(0));
    check("abort_cout", 32'(cout), 32'(0));
    last_sum  = '0;
    last_cout = 1'b0;
    @(negedge clk);
    check("abort_still_idle", 32'({busy, done}), 32'(0));
    rst_n = 1'b1;
    drive_start('{8'h03, 8'h04, 1'b0, 8'h07, 1'b0}, 1'b1);
    wait_result("post_rst", 100);
    @(negedge clk);
    check("post_rst_done_pulse", 32'(done), 32'(0));

    // Start held in the DONE cycle chains straight into a new RUN.
    drive_start('{8'h55, 8'h22, 1'b0, 8'h77, 1'b0}, 1'b1);
    wait_result("chain_a", 100);
    v = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    drive_start(v, 1'b1);
    check("chain_busy_immediate", 32'(busy), 32'(1));
    wait_result("chain_b", 100);
    @(negedge clk);
    check("chain_done_pulse", 32'(done), 32'(0));
    check("chain_sb_drained", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning operand/result bit width (legal range 2..32).
REQ-002 SHALL provide clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide start, input, 1, one-cycle request to begin an addition.
REQ-005 SHALL provide a, input, WIDTH, first operand, sampled only when start is accepted.
REQ-006 SHALL provide b, input, WIDTH, second operand, sampled only when start is accepted.
REQ-007 SHALL provide cin, input, 1, carry-in, sampled only when start is accepted.
REQ-008 SHALL provide busy, output, 1, high while bits are being processed.
REQ-009 SHALL provide done, output, 1, one-cycle pulse marking a new valid result.
REQ-010 SHALL provide sum, output, WIDTH, registered result of the last completed addition.
REQ-011 SHALL provide cout, output, 1, registered carry-out of the last completed addition.
REQ-012 SHALL be built with one clock; reset is asynchronous and active-low.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE: load a and b into shift registers, load cin into the carry flop, clear the bit counter, go to RUN.
REQ-015 SHALL, on each RUN edge, add a_sr[0], b_sr[0] and carry; shift the sum bit into result MSB; shift a_sr/b_sr right; update carry; increment counter.
REQ-016 SHALL leave RUN after exactly WIDTH RUN edges, then load sum and cout from the result register and carry, and enter DONE.
REQ-017 SHALL give latency: start sampled at edge 0, done high in the cycle after edge WIDTH.
REQ-018 SHALL drive busy=1 in RUN only; done=1 in DONE only, for exactly one cycle.
REQ-019 SHALL, from DONE, go to RUN if start=1, else to IDLE.
REQ-020 SHALL ignore start in RUN, leaving operands, counter and outputs unaffected.
REQ-021 SHALL hold sum and cout at the previous result throughout a new RUN, until the completing edge.
REQ-022 SHALL use modulo-2^WIDTH arithmetic; overflow is reported only through cout.
REQ-023 SHALL clear the counter at load and compare it against WIDTH-1 for the final bit; it never wraps.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE and all registers to zero: busy=0, done=0, sum=0, cout=0.
REQ-025 SHALL abort any in-progress addition on reset mid-RUN, produce no done pulse, and discard the partial result.
REQ-026 SHALL accept a start on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/DONE) and the default WIDTH constant in shared package serial_adder_pkg.
REQ-028 SHALL use one sub-module serial_add_cell: a 1-bit full adder built from two half-add stages (XOR/AND) plus an OR for carry.
REQ-029 SHALL keep all sequential logic in serial_adder; serial_add_cell is purely combinational.

Verification (WIDTH=8)
REQ-030 SHALL pass: a=0x00, b=0x00, cin=0, start at edge 0 -> busy edges 1..8, done high after edge 8, sum=0x00, cout=0.
REQ-031 SHALL pass: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, single done pulse.
REQ-032 SHALL pass: a=0x7F, b=0x80, cin=1 -> sum=0x00, cout=1.
REQ-033 SHALL pass: a=0xA5, b=0x5A, cin=0, plus start and a=0x11 mid-RUN -> ignored; sum=0xFF, cout=0, done at original time.
REQ-034 SHALL pass: rst_n low during 4th RUN edge -> outputs zero immediately, no done; then 0x03+0x04 -> sum=0x07, cout=0.
REQ-035 SHALL pass: start held in DONE cycle with 0x10+0x20 -> immediate RUN, prior sum held 8 cycles, then sum=0x30 with second done pulse.
